seqcirc_param: RTL and testbench
================================

// Module: seqcirc_param
// PURPOSE
//  Parametrised multi-cycle four-operand datapath; next generation of the seqcirc unit.
//  Adds generic WIDTH, a 2-bit mode (SUM/DIFF/MAC/MAX), a sticky overflow flag and a busy output.
//  Operands are latched on start; one ALU step per clock; done/result presented to the controlling FSM.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=2)
//  SIGNED  0  1: two's-complement compare (MAX) and signed overflow; 0: unsigned
// PORTS
//  clk     in   1      single clock, rising edge
//  reset   in   1      asynchronous, active-low reset (0 = reset asserted)
//  start   in   1      request; sampled only when idle or done
//  mode    in   2      00 SUM, 01 DIFF, 10 MAC, 11 MAX; latched with operands
//  A,B,C,D in   WIDTH  operands, latched on the accepting edge
//  result  out  WIDTH  accumulator; valid while done=1
//  done    out  1      operation complete, result stable
//  busy    out  1      operation in progress (EXEC/MUL states)
//  ovf     out  1      sticky overflow for the current operation; valid with done
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, result=0, done=0, busy=0, ovf=0, operand regs=0.
//  Reset mid-operation aborts immediately; no partial result or done survives.
//  States: IDLE, EXEC, MUL1, MUL2, DONE.
//  Accept: edge t with start=1 in IDLE or DONE -> latch A..D,mode; done=0, ovf=0, busy=1.
//   SUM/DIFF/MAX: acc=A at t; edge t+1 acc op B; t+2 acc op C; t+3 acc op D, ->DONE.
//    SUM: acc+=x. DIFF: +B, -C, -D, i.e. (A+B)-(C+D). MAX: acc=max(acc,x).
//   MAC: acc=0 at t; MUL1 edges t+1..t+WIDTH shift-add A*B (one multiplier bit/edge);
//    MUL2 edges t+WIDTH+1..t+2*WIDTH add C*D into acc; ->DONE at t+2*WIDTH.
//  DONE: done=1, busy=0, result/ovf held. start=0 -> IDLE (done drops next edge);
//   start=1 -> new accept on that edge (back-to-back, done low for whole next op).
//  start while busy ignored; operands/mode changes while busy ignored.
//  Arithmetic modulo 2^WIDTH; result truncated to WIDTH.
//  ovf (sticky, OR over all steps): SIGNED=0 carry-out on add / borrow on subtract;
//   SIGNED=1 two's-complement overflow; MAC: any partial-product/accumulate bit
//   beyond WIDTH (unsigned) or out of range (signed, operands sign-magnitude-corrected).
//   MAX never sets ovf.
//  MAX ties: keep acc (first operand wins); indistinguishable in result.
//  WIDTH=2 minimum; MAC latency scales 2*WIDTH, SUM/DIFF/MAX fixed 3.
// STRUCTURE
//  seqcirc_defs.vh (shared include): mode encodings MODE_SUM/DIFF/MAC/MAX,
//   state encodings ST_IDLE/EXEC/MUL1/MUL2/DONE.
//  Sub-module seqcirc_alu: combinational one-step unit (add/sub/max, carry/overflow out),
//   WIDTH/SIGNED passed through; top holds FSM, operand regs, step counter, shift regs.
//  Step counter width $clog2(WIDTH)+1.
// TESTING (WIDTH=8 unless stated; done edge counted from accepting edge t)
//  1 SUM A=01 B=02 C=FF D=FE -> result=00, ovf=1, done=1 at t+3, busy high t..t+3.
//  2 DIFF A=FE B=01 C=01 D=04 -> result=FA, ovf=0, done at t+3.
//  3 MAC A=03 B=05 C=04 D=06 -> result=27, ovf=0, done at t+16; A=10 B=10 -> ovf=1.
//  4 MAX A=01 B=FF C=7F D=80: SIGNED=0 -> FF; SIGNED=1 -> 7F; ovf=0 both.
//  5 reset=0 at t+5 of MAC -> result=00, done=0, busy=0 async; next start runs normally.
//  6 start toggled during EXEC ignored; start held in DONE restarts with new operands;
//    WIDTH=16 SUM FFFF+0001+0000+0000 -> 0000, ovf=1.

Source files
------------

// File: rtl/seqcirc_param_pkg.sv
// Shared encodings for the seqcirc_param datapath: operation modes, controller
// states and the one-step ALU operation select.
package seqcirc_param_pkg;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'b00,
    MODE_DIFF = 2'b01,
    MODE_MAC  = 2'b10,
    MODE_MAX  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MAX = 2'd2
  } alu_op_e;

endpackage

// File: rtl/seqcirc_param_if.sv
// Request/response bundle of seqcirc_param: start, mode and operands in,
// result and status flags out.
interface seqcirc_param_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             ovf;

  modport master (output start, mode, A, B, C, D, input result, done, busy, ovf);
  modport slave  (input start, mode, A, B, C, D, output result, done, busy, ovf);
endinterface

// File: rtl/seqcirc_param_alu.sv
// Combinational single-step unit: acc op x with carry/borrow (unsigned) or
// two's-complement overflow (signed). MAX keeps acc on ties and never flags.
module seqcirc_param_alu
  import seqcirc_param_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           x_gt;

  // One accumulate step with overflow detection
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, x};
    diff = {1'b0, acc} - {1'b0, x};
    x_gt = (SIGNED != 0) ? ($signed(x) > $signed(acc)) : (x > acc);
    res  = acc;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        ovf = (SIGNED != 0) ? ((acc[WIDTH-1] == x[WIDTH-1]) && (res[WIDTH-1] != acc[WIDTH-1]))
                            : sum[WIDTH];
      end
      OP_SUB: begin
        res = diff[WIDTH-1:0];
        ovf = (SIGNED != 0) ? ((acc[WIDTH-1] != x[WIDTH-1]) && (res[WIDTH-1] != acc[WIDTH-1]))
                            : diff[WIDTH];
      end
      OP_MAX: res = x_gt ? x : acc;
      default: res = acc;
    endcase
  end

endmodule

// File: rtl/seqcirc_param.sv
// Multi-cycle four-operand datapath (SUM/DIFF/MAC/MAX) with sticky overflow.
// Operands latch on the accepting edge; one ALU step per clock afterwards.
module seqcirc_param
  import seqcirc_param_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          reset,
  seqcirc_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  // Largest product magnitude representable as a negative signed result.
  localparam logic [2*WIDTH-1:0] SMAG_LIM = (2*WIDTH)'(1) << (WIDTH - 1);

  state_e             state_q, state_d;
  mode_e              mode_q;
  logic [WIDTH-1:0]   a_q, b_q, c_q, d_q, acc_q;
  logic               ovf_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               accept, last_bit;
  alu_op_e            alu_op;
  logic [WIDTH-1:0]   alu_x, alu_res;
  logic               alu_ovf;
  logic [WIDTH-1:0]   mul_x, mul_y, mag_x, mag_y, prod_trunc;
  logic               mul_bit, mul_neg, prod_fits;

  function automatic logic [WIDTH-1:0] magnitude(logic [WIDTH-1:0] v);
    return ((SIGNED != 0) && v[WIDTH-1]) ? -v : v;
  endfunction

  assign accept      = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_bit    = (cnt_q == CW'(WIDTH - 1));
  assign bus.result  = acc_q;
  assign bus.ovf     = ovf_q;

  // Next-state and status decode
  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        bus.done = (state_q == ST_DONE);
        if (accept) state_d = (mode_e'(bus.mode) == MODE_MAC) ? ST_MUL1 : ST_EXEC;
        else        state_d = ST_IDLE;
      end
      ST_EXEC: begin
        bus.busy = 1'b1;
        if (cnt_q == CW'(2)) state_d = ST_DONE;
      end
      ST_MUL1: begin
        bus.busy = 1'b1;
        if (last_bit) state_d = ST_MUL2;
      end
      ST_MUL2: begin
        bus.busy = 1'b1;
        if (last_bit) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift-add multiplier step on operand magnitudes; sign applied to the finished product
  always_comb begin
    mul_x      = (state_q == ST_MUL2) ? c_q : a_q;
    mul_y      = (state_q == ST_MUL2) ? d_q : b_q;
    mag_x      = magnitude(mul_x);
    mag_y      = magnitude(mul_y);
    mul_bit    = |(mag_y & (WIDTH'(1) << cnt_q));
    mul_neg    = (SIGNED != 0) && (mul_x[WIDTH-1] ^ mul_y[WIDTH-1]);
    prod_d     = prod_q;
    if (mul_bit) prod_d = prod_q + ({{WIDTH{1'b0}}, mag_x} << cnt_q);
    prod_trunc = mul_neg ? -prod_d[WIDTH-1:0] : prod_d[WIDTH-1:0];
    if (SIGNED != 0) prod_fits = mul_neg ? (prod_d <= SMAG_LIM) : (prod_d < SMAG_LIM);
    else             prod_fits = (prod_d[2*WIDTH-1:WIDTH] == '0);
  end

  // ALU operand and operation select
  always_comb begin
    alu_op = OP_ADD;
    alu_x  = prod_trunc;
    if (state_q == ST_EXEC) begin
      alu_x = (cnt_q == '0) ? b_q : (cnt_q == CW'(1)) ? c_q : d_q;
      case (mode_q)
        MODE_DIFF: alu_op = (cnt_q == '0) ? OP_ADD : OP_SUB;
        MODE_MAX:  alu_op = OP_MAX;
        default:   alu_op = OP_ADD;
      endcase
    end
  end

  seqcirc_param_alu #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_alu (
    .acc (acc_q),
    .x   (alu_x),
    .op  (alu_op),
    .res (alu_res),
    .ovf (alu_ovf)
  );

  // Controller state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand latch, accumulator, sticky overflow and step counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      mode_q <= MODE_SUM;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else if (accept) begin
      a_q    <= bus.A;
      b_q    <= bus.B;
      c_q    <= bus.C;
      d_q    <= bus.D;
      mode_q <= mode_e'(bus.mode);
      acc_q  <= (mode_e'(bus.mode) == MODE_MAC) ? '0 : bus.A;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          acc_q <= alu_res;
          ovf_q <= ovf_q | alu_ovf;
          cnt_q <= cnt_q + CW'(1);
        end
        ST_MUL1, ST_MUL2: begin
          // the product is folded into acc only on its last multiplier bit
          if (last_bit) begin
            acc_q  <= alu_res;
            ovf_q  <= ovf_q | alu_ovf | !prod_fits;
            cnt_q  <= '0;
            prod_q <= '0;
          end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seqcirc_param.sv
// Scoreboard bench for seqcirc_param: three instances (8-bit unsigned,
// 8-bit signed, 16-bit unsigned), expected results from an arithmetic model.
module tb_seqcirc_param;
  import seqcirc_param_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          lat;
    int          acc_cyc;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seqcirc_param_if #(.WIDTH(8))  bus0 ();
  seqcirc_param_if #(.WIDTH(8))  bus1 ();
  seqcirc_param_if #(.WIDTH(16)) bus2 ();

  seqcirc_param #(.WIDTH(8),  .SIGNED(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  seqcirc_param #(.WIDTH(8),  .SIGNED(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  seqcirc_param #(.WIDTH(16), .SIGNED(0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  function automatic void check(string nm, longint act, longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endfunction

  // ---------------- reference model ----------------
  function automatic longint sx(longint v, int w, bit sg);
    longint half = longint'(1) << (w - 1);
    return (sg && v >= half) ? v - (longint'(1) << w) : v;
  endfunction

  function automatic bit in_range(longint v, int w, bit sg);
    longint md = longint'(1) << w;
    if (sg) return (v >= -(md / 2)) && (v < md / 2);
    return (v >= 0) && (v < md);
  endfunction

  function automatic longint wrap(longint v, int w);
    longint md = longint'(1) << w;
    return ((v % md) + md) % md;
  endfunction

  function automatic exp_t model(int w, bit sg, logic [1:0] m,
                                 longint a, longint b, longint c, longint d);
    exp_t   e;
    longint ops[3];
    longint acc, t, p1, p2;
    bit     ov = 1'b0;
    ops[0] = b; ops[1] = c; ops[2] = d;
    acc = a;
    if (m == 2'b10) begin
      p1  = sx(a, w, sg) * sx(b, w, sg);
      p2  = sx(c, w, sg) * sx(d, w, sg);
      t   = p1 + p2;
      ov  = !in_range(p1, w, sg) || !in_range(p2, w, sg) || !in_range(t, w, sg);
      acc = wrap(t, w);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m == 2'b11) begin
          if (sx(ops[i], w, sg) > sx(acc, w, sg)) acc = ops[i];
        end else begin
          t   = (m == 2'b01 && i > 0) ? sx(acc, w, sg) - sx(ops[i], w, sg)
                                      : sx(acc, w, sg) + sx(ops[i], w, sg);
          ov  = ov | !in_range(t, w, sg);
          acc = wrap(t, w);
        end
      end
    end
    e.res = acc[15:0];
    e.ovf = ov;
    e.lat = (m == 2'b10) ? 2 * w : 3;
    e.acc_cyc = 0;
    e.nm = "";
    return e;
  endfunction

  // ---------------- instance access helpers ----------------
  function automatic int width_of(int sel);
    return (sel == 2) ? 16 : 8;
  endfunction

  task automatic drive(int sel, logic s, logic [1:0] m,
                       logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
    case (sel)
      0: begin bus0.start = s; bus0.mode = m; bus0.A = a[7:0]; bus0.B = b[7:0]; bus0.C = c[7:0]; bus0.D = d[7:0]; end
      1: begin bus1.start = s; bus1.mode = m; bus1.A = a[7:0]; bus1.B = b[7:0]; bus1.C = c[7:0]; bus1.D = d[7:0]; end
      default: begin bus2.start = s; bus2.mode = m; bus2.A = a; bus2.B = b; bus2.C = c; bus2.D = d; end
    endcase
  endtask

  function automatic logic get_done(int sel);
    case (sel)
      0: return bus0.done;
      1: return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  function automatic logic get_busy(int sel);
    case (sel)
      0: return bus0.busy;
      1: return bus1.busy;
      default: return bus2.busy;
    endcase
  endfunction

  // ---------------- stimulus tasks ----------------
  // Called at a falling edge; the next rising edge is the accepting edge t.
  task automatic issue(int sel, logic [1:0] m, logic [15:0] a, logic [15:0] b,
                       logic [15:0] c, logic [15:0] d, string nm, bit push);
    exp_t e = model(width_of(sel), sel == 1, m, longint'(a), longint'(b), longint'(c), longint'(d));
    e.acc_cyc = cyc + 1;
    e.nm = nm;
    drive(sel, 1'b1, m, a, b, c, d);
    if (push) begin
      case (sel)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(negedge clk);
  endtask

  task automatic wait_done(int sel, string nm);
    int n = 0;
    while (!get_done(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!get_done(sel)) begin
      n_chk++;
      $display("FAIL %s timeout: done=0 expected 1 within 100 cycles", nm);
    end
  endtask

  task automatic run(int sel, logic [1:0] m, logic [15:0] a, logic [15:0] b,
                     logic [15:0] c, logic [15:0] d, string nm);
    issue(sel, m, a, b, c, d, nm, 1'b1);
    drive(sel, 1'b0, m, a, b, c, d);
    check({nm, " busy@t"}, get_busy(sel), 1);
    check({nm, " done@t"}, get_done(sel), 0);
    wait_done(sel, nm);
    @(negedge clk);
  endtask

  // ---------------- monitors: pop and compare on each rising done ----------------
  logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;

  // Monitor for the 8-bit unsigned instance
  always @(negedge clk) begin
    exp_t e;
    if (bus0.done && !pd0) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL dut0 unexpected done: result=%0h expected no completion", bus0.result);
      end else begin
        e = q0.pop_front();
        check({e.nm, " result"}, bus0.result, e.res);
        check({e.nm, " ovf"}, bus0.ovf, e.ovf);
        check({e.nm, " latency"}, cyc - e.acc_cyc, e.lat);
      end
    end
    pd0 <= bus0.done;
  end

  // Monitor for the 8-bit signed instance
  always @(negedge clk) begin
    exp_t e;
    if (bus1.done && !pd1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL dut1 unexpected done: result=%0h expected no completion", bus1.result);
      end else begin
        e = q1.pop_front();
        check({e.nm, " result"}, bus1.result, e.res);
        check({e.nm, " ovf"}, bus1.ovf, e.ovf);
        check({e.nm, " latency"}, cyc - e.acc_cyc, e.lat);
      end
    end
    pd1 <= bus1.done;
  end

  // Monitor for the 16-bit unsigned instance
  always @(negedge clk) begin
    exp_t e;
    if (bus2.done && !pd2) begin
      if (q2.size() == 0) begin
        n_chk++;
        $display("FAIL dut2 unexpected done: result=%0h expected no completion", bus2.result);
      end else begin
        e = q2.pop_front();
        check({e.nm, " result"}, bus2.result, e.res);
        check({e.nm, " ovf"}, bus2.ovf, e.ovf);
        check({e.nm, " latency"}, cyc - e.acc_cyc, e.lat);
      end
    end
    pd2 <= bus2.done;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] mask, ra, rb, rc, rd;
    int          sel;
    logic [1:0]  rm;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 2'b00, '0, '0, '0, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset result", bus0.result, 0);
    check("reset done", bus0.done, 0);
    check("reset busy", bus0.busy, 0);
    check("reset ovf", bus0.ovf, 0);
    check("reset dut2 result", bus2.result, 0);
    reset = 1'b1;
    @(negedge clk);

    run(0, MODE_SUM,  16'h01, 16'h02, 16'hFF, 16'hFE, "sum carry");
    run(0, MODE_DIFF, 16'hFE, 16'h01, 16'h01, 16'h04, "diff");
    run(0, MODE_DIFF, 16'h01, 16'h00, 16'h02, 16'h00, "diff borrow");
    run(0, MODE_MAC,  16'h03, 16'h05, 16'h04, 16'h06, "mac small");
    run(0, MODE_MAC,  16'h10, 16'h10, 16'h00, 16'h00, "mac ovf");
    run(0, MODE_MAX,  16'h01, 16'hFF, 16'h7F, 16'h80, "max unsigned");
    run(1, MODE_MAX,  16'h01, 16'hFF, 16'h7F, 16'h80, "max signed");
    run(1, MODE_SUM,  16'h7F, 16'h01, 16'h00, 16'h00, "signed sum ovf");
    run(1, MODE_MAC,  16'h80, 16'h01, 16'h00, 16'h00, "signed mac -128");
    run(1, MODE_MAC,  16'h80, 16'hFF, 16'h00, 16'h00, "signed mac +128");
    run(1, MODE_MAC,  16'hFD, 16'h05, 16'h04, 16'hFA, "signed mac neg");
    run(2, MODE_SUM,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, "w16 sum");
    run(2, MODE_MAC,  16'h0100, 16'h00FF, 16'h0002, 16'h0003, "w16 mac");

    // asynchronous abort in the middle of a MAC
    issue(0, MODE_MAC, 16'h07, 16'h09, 16'h0B, 16'h0D, "mac abort", 1'b0);
    drive(0, 1'b0, MODE_MAC, '0, '0, '0, '0);
    repeat (4) @(negedge clk);
    check("abort busy before reset", bus0.busy, 1);
    #1 reset = 1'b0;
    #1;
    check("abort busy", bus0.busy, 0);
    check("abort done", bus0.done, 0);
    check("abort result", bus0.result, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset while a finished result is presented
    issue(0, MODE_SUM, 16'h10, 16'h20, 16'h30, 16'h41, "sum before reset", 1'b1);
    drive(0, 1'b0, MODE_SUM, '0, '0, '0, '0);
    wait_done(0, "sum before reset");
    #1 reset = 1'b0;
    #1;
    check("done-reset result", bus0.result, 0);
    check("done-reset done", bus0.done, 0);
    check("done-reset ovf", bus0.ovf, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(0, MODE_MAC, 16'h03, 16'h05, 16'h04, 16'h06, "mac after reset");

    // start and operand changes while busy are ignored
    issue(0, MODE_SUM, 16'h10, 16'h20, 16'h30, 16'h40, "sum busy start", 1'b1);
    drive(0, 1'b1, MODE_MAC, 16'hFF, 16'hFF, 16'hFF, 16'hFF);
    @(negedge clk);
    drive(0, 1'b0, MODE_MAC, 16'hFF, 16'hFF, 16'hFF, 16'hFF);
    wait_done(0, "sum busy start");
    @(negedge clk);

    // back-to-back: start asserted while done
    issue(0, MODE_SUM, 16'h01, 16'h01, 16'h01, 16'h01, "b2b first", 1'b1);
    drive(0, 1'b0, MODE_SUM, '0, '0, '0, '0);
    wait_done(0, "b2b first");
    issue(0, MODE_MAX, 16'h05, 16'h09, 16'h03, 16'h07, "b2b second", 1'b1);
    drive(0, 1'b0, MODE_SUM, '0, '0, '0, '0);
    check("b2b done dropped", bus0.done, 0);
    check("b2b busy", bus0.busy, 1);
    wait_done(0, "b2b second");
    @(negedge clk);

    // randomized operations across all three instances
    for (int i = 0; i < 30; i++) begin
      sel  = int'($urandom_range(0, 2));
      rm   = 2'($urandom_range(0, 3));
      mask = (sel == 2) ? 16'hFFFF : 16'h00FF;
      ra = 16'($urandom) & mask;
      rb = 16'($urandom) & mask;
      rc = 16'($urandom) & mask;
      rd = 16'($urandom) & mask;
      run(sel, rm, ra, rb, rc, rd, $sformatf("rand%0d dut%0d mode%0d", i, sel, rm));
    end

    repeat (2) @(negedge clk);
    check("dut0 queue drained", q0.size(), 0);
    check("dut1 queue drained", q1.size(), 0);
    check("dut2 queue drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
